// File: rtl/ising_config.sv
// Shared definitions for the ising front-end blocks: peak detector states,
// sample geometry and the GPIO config-bus field layout.
package ising_config;

   localparam int PD_NUM_REGS = 3;
   localparam int PD_SAMPLE_W = 16;
   localparam int GPIO_ADDR_W = 15;

   typedef enum logic [1:0] {
      ARMED   = 2'd0,
      WINDOW  = 2'd1,
      HOLDOFF = 2'd2
   } pd_state_t;

   // Signed max; on a tie the current value is kept.
   function automatic logic signed [PD_SAMPLE_W-1:0] pd_smax(
      input logic signed [PD_SAMPLE_W-1:0] cur,
      input logic signed [PD_SAMPLE_W-1:0] cand
   );
      return (cand > cur) ? cand : cur;
   endfunction

endpackage

// File: rtl/config_reg.sv
// 16-bit config register on the shared GPIO bus.
// Bus word: [31] write strobe, [30:16] register address, [15:0] data.
module config_reg
   import ising_config::*;
#(
   parameter int unsigned ADDR = 0
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [31:0]            gpio_in,
   output logic [PD_SAMPLE_W-1:0] value
);

   localparam logic [GPIO_ADDR_W-1:0] ADDR_F = GPIO_ADDR_W'(ADDR);

   logic                   hit_s;
   logic [PD_SAMPLE_W-1:0] value_r;

   assign hit_s = gpio_in[31] && (gpio_in[30:16] == ADDR_F);
   assign value = value_r;

   // Capture the data field when our address is strobed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         value_r <= '0;
      end else if (hit_s) begin
         value_r <= gpio_in[PD_SAMPLE_W-1:0];
      end else begin
         value_r <= value_r;
      end
   end

endmodule

// File: rtl/lane_max_tree.sv
// Combinational signed max over all lanes of a beat, built as a binary
// comparator tree in heap order (node 1 is the root, leaves at lanes..2*lanes-1).
module lane_max_tree
   import ising_config::*;
#(
   parameter int lanes = 8
)(
   input  logic        [PD_SAMPLE_W*lanes-1:0] data,
   output logic signed [PD_SAMPLE_W-1:0]       max_val
);

   logic signed [PD_SAMPLE_W-1:0] node_s [1:2*lanes-1];

   // Load leaves, then reduce pairwise toward the root.
   always_comb begin
      for (int i = 0; i < lanes; i++) begin
         node_s[lanes+i] = data[i*PD_SAMPLE_W +: PD_SAMPLE_W];
      end
      for (int i = lanes - 1; i >= 1; i--) begin
         node_s[i] = pd_smax(node_s[2*i], node_s[2*i+1]);
      end
      max_val = node_s[1];
   end

endmodule

// File: rtl/adc_peak_detector.sv
// Threshold-triggered peak detector on a multi-lane ADC stream: opens a
// window on a threshold crossing, emits the window maximum, then holds off.
module adc_peak_detector
   import ising_config::*;
#(
   parameter int unsigned start_addr = 0,
   parameter int          lanes      = 8
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic [31:0]                  gpio_in,
   input  logic [PD_SAMPLE_W*lanes-1:0] s_data,
   input  logic                         s_valid,
   output logic [PD_SAMPLE_W-1:0]       peak_out,
   output logic                         peak_out_valid,
   output logic                         busy
);

   logic        [PD_SAMPLE_W-1:0] cfg_s [PD_NUM_REGS];
   logic signed [PD_SAMPLE_W-1:0] threshold_s;
   logic        [PD_SAMPLE_W-1:0] window_len_s;
   logic        [PD_SAMPLE_W-1:0] holdoff_len_s;

   for (genvar r = 0; r < PD_NUM_REGS; r++) begin : g_cfg
      config_reg #(.ADDR(start_addr + r)) u_cfg (
         .clk     (clk),
         .rst     (rst),
         .gpio_in (gpio_in),
         .value   (cfg_s[r])
      );
   end

   assign threshold_s   = signed'(cfg_s[0]);
   assign window_len_s  = cfg_s[1];
   assign holdoff_len_s = cfg_s[2];

   logic signed [PD_SAMPLE_W-1:0] tree_max_s;
   logic                          hit_s;

   lane_max_tree #(.lanes(lanes)) u_tree (
      .data    (s_data),
      .max_val (tree_max_s)
   );

   // Any lane strictly above threshold.
   always_comb begin
      hit_s = 1'b0;
      for (int i = 0; i < lanes; i++) begin
         if ($signed(s_data[i*PD_SAMPLE_W +: PD_SAMPLE_W]) > threshold_s) begin
            hit_s = 1'b1;
         end else begin
            hit_s = hit_s;
         end
      end
   end

   logic signed [PD_SAMPLE_W-1:0] beat_max_r;
   logic                          beat_hit_r;
   logic                          s1_valid_r;

   // Stage 1: beat summary registered on valid beats only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         beat_max_r <= '0;
         beat_hit_r <= 1'b0;
         s1_valid_r <= 1'b0;
      end else begin
         s1_valid_r <= s_valid;
         if (s_valid) begin
            beat_max_r <= tree_max_s;
            beat_hit_r <= hit_s;
         end else begin
            beat_max_r <= beat_max_r;
            beat_hit_r <= beat_hit_r;
         end
      end
   end

   pd_state_t                     state_r,    state_n;
   logic signed [PD_SAMPLE_W-1:0] run_max_r,  run_max_n;
   logic        [PD_SAMPLE_W-1:0] win_left_r, win_left_n;
   logic        [PD_SAMPLE_W-1:0] hold_len_r, hold_len_n;
   logic        [PD_SAMPLE_W-1:0] hold_cnt_r, hold_cnt_n;
   logic signed [PD_SAMPLE_W-1:0] peak_r,     peak_n;
   logic                          peak_vld_r, peak_vld_n;
   logic        [PD_SAMPLE_W-1:0] wl_init_s;

   // A zero window length behaves as a single-beat window.
   assign wl_init_s = (window_len_s == 16'd0) ? 16'd0 : (window_len_s - 16'd1);

   // FSM next-state and datapath; everything stalls while s1_valid_r is low.
   always_comb begin
      state_n    = state_r;
      run_max_n  = run_max_r;
      win_left_n = win_left_r;
      hold_len_n = hold_len_r;
      hold_cnt_n = hold_cnt_r;
      peak_n     = peak_r;
      peak_vld_n = 1'b0;
      if (s1_valid_r) begin
         case (state_r)
            ARMED: begin
               if (beat_hit_r) begin
                  run_max_n  = beat_max_r;
                  win_left_n = wl_init_s;
                  hold_len_n = holdoff_len_s;
                  if (wl_init_s == 16'd0) begin
                     peak_n     = beat_max_r;
                     peak_vld_n = 1'b1;
                     hold_cnt_n = holdoff_len_s;
                     state_n    = (holdoff_len_s == 16'd0) ? ARMED : HOLDOFF;
                  end else begin
                     state_n = WINDOW;
                  end
               end else begin
                  state_n = ARMED;
               end
            end
            WINDOW: begin
               run_max_n  = pd_smax(run_max_r, beat_max_r);
               win_left_n = win_left_r - 16'd1;
               if (win_left_r == 16'd1) begin
                  peak_n     = run_max_n;
                  peak_vld_n = 1'b1;
                  hold_cnt_n = hold_len_r;
                  state_n    = (hold_len_r == 16'd0) ? ARMED : HOLDOFF;
               end else begin
                  state_n = WINDOW;
               end
            end
            HOLDOFF: begin
               hold_cnt_n = hold_cnt_r - 16'd1;
               if (hold_cnt_r <= 16'd1) begin
                  state_n = ARMED;
               end else begin
                  state_n = HOLDOFF;
               end
            end
            default: begin
               state_n = ARMED;
            end
         endcase
      end else begin
         state_n = state_r;
      end
   end

   // FSM and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= ARMED;
         run_max_r  <= '0;
         win_left_r <= '0;
         hold_len_r <= '0;
         hold_cnt_r <= '0;
         peak_r     <= '0;
         peak_vld_r <= 1'b0;
      end else begin
         state_r    <= state_n;
         run_max_r  <= run_max_n;
         win_left_r <= win_left_n;
         hold_len_r <= hold_len_n;
         hold_cnt_r <= hold_cnt_n;
         peak_r     <= peak_n;
         peak_vld_r <= peak_vld_n;
      end
   end

   assign peak_out       = peak_r;
   assign peak_out_valid = peak_vld_r;
   assign busy           = (state_r != ARMED);

endmodule

// File: doc/adc_peak_detector.md
# adc_peak_detector

- Sits between the RFSoC ADC AXI-Stream output and `input_scaler`.
- Scans 8 parallel signed 16-bit samples per clock and opens a measurement window when any sample crosses a programmable threshold.
- Tracks the maximum sample over the window and emits it as a single-cycle `peak_out`/`peak_out_valid` pulse, which `input_scaler` consumes directly.
- After each peak, a programmable holdoff suppresses retriggering on pulse tails.

## Interface
- `start_addr`, default 0: GPIO config bus base address. This block claims `start_addr`..`start_addr+2`.
- `lanes`, default 8: samples per beat. Must be a power of two, ≥2.
- `clk` input, 1 bit: clock.
- `rst` input, 1 bit: reset, asynchronous, active-low.
- `gpio_in` input, 32 bits: shared config bus, decoded by `config_reg` instances.
- `s_data` input, 16*`lanes` bits: ADC beat. Lane i is `s_data[i*16+:16]`, signed two's complement. Lane 0 is the earliest sample in time.
- `s_valid` input, 1 bit: beat qualifier. The block has no backpressure; every valid beat is consumed.
- `peak_out` output, 16 bits: signed peak value for the completed window.
- `peak_out_valid` output, 1 bit: one-cycle pulse qualifying `peak_out`.
- `busy` output, 1 bit: high whenever the FSM is not in ARMED.

## Operation
Config registers (16-bit `config_reg` on `gpio_in`):
- `start_addr+0` `threshold`: signed.
- `start_addr+1` `window_len`: unsigned, counted in valid beats. 0 is treated as 1.
- `start_addr+2` `holdoff_len`: unsigned, counted in valid beats.

Stage 1 (registered, only on `s_valid`):
- `beat_max`: signed max over all lanes, computed by a binary comparator tree.
- `beat_hit`: set if any lane > `threshold` (strict, signed).
- `s1_valid`: copy of `s_valid`.

FSM, which advances only when `s1_valid` is high:
- ARMED:
  - If `beat_hit`: `run_max` ← `beat_max`, latch `win_left` ← max(`window_len`,1)−1, latch `hold_len` ← `holdoff_len`.
  - If `win_left` = 0, emit and go to HOLDOFF (or ARMED if `hold_len` = 0). Otherwise go to WINDOW.
- WINDOW:
  - `run_max` ← max(`run_max`, `beat_max`). The threshold is ignored.
  - Decrement `win_left`. On the beat where it reaches 0 (after the update), emit `peak_out` = final `run_max`.
  - Then go to HOLDOFF, or to ARMED if `hold_len` = 0.
- HOLDOFF:
  - Beats are discarded. Count `hold_len` beats, then go to ARMED.
  - The first beat after the last holdoff beat is eligible to trigger.

Other rules:
- Max comparisons are signed; ties keep the existing value.
- Config writes take effect as follows: `threshold` applies on the next ARMED evaluation. `window_len`/`holdoff_len` changes do not affect a window in progress.
- A gap in `s_valid` stalls the FSM and counters and does not end a window.

## Timing
- Reset values: `peak_out` = 0, `peak_out_valid` = 0, `busy` = 0; FSM in ARMED; all stage-1 registers 0.
- Reset asserted mid-window aborts without emitting. The first valid beat after reset release may trigger.
- Latency: a final window beat presented on `s_data` in cycle t gives `peak_out_valid` = 1 in cycle t+2, for exactly one cycle. `peak_out` holds its value until the next emission.
- `busy` rises in the cycle after the trigger beat reaches the FSM (t+2). It falls in the cycle after the FSM re-enters ARMED.
- Maximum emission rate: one peak per beat (`window_len` ≤ 1, `holdoff_len` = 0 while continuously triggering).

## Structure
- Add to `ising_config`:
  - the FSM state enum `pd_state_t` {ARMED, WINDOW, HOLDOFF};
  - the constants `PD_NUM_REGS` = 3 and `PD_SAMPLE_W` = 16.
- Sub-module `lane_max_tree`: a parameterised signed max reduction over `lanes` inputs, combinational, with the stage-1 register in the parent.
- Three `config_reg` instances.

## Test plan
- Threshold 1000, `window_len` 4, `holdoff_len` 0. Beats with max {1200, 3000, 2500, 900}, rest of each beat 0 → `peak_out` = 3000, one pulse, 2 cycles after the 4th beat.
- Same config, all samples ≤ 1000 for 100 beats; one sample exactly 1000 → no pulse, `busy` stays 0.
- `window_len` 3, `holdoff_len` 5, continuous beats all at 2000 → pulses every 8 beats, each with `peak_out` = 2000.
- Negative domain: threshold −500, window 2, beats max {−400, −450} → `peak_out` = −400. A `s_valid` gap of 3 cycles mid-window does not change the result.
- `window_len` 0 with a trigger beat max 1500 → immediate emission, `peak_out` = 1500 at t+2.
- `rst` pulsed low during WINDOW → no pulse, all outputs 0. A post-reset trigger emits normally.
